bip_cpu_stall: RTL and testbench

BIP_CPU_STALL -- requirements
Module: bip_cpu_stall

---
 rtl/bip_cpu_stall_if.sv | 30 +++
 rtl/bip_cpu_stall.sv | 131 +++++++++++++
 tb/tb_bip_cpu_stall.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bip_cpu_stall_if.sv
// Memory/program bus of the stalling BIP core. The core is the master;
// the memories (or a testbench standing in for them) take the slave view.
interface bip_cpu_stall_if #(
  parameter int NB_INSTRUC = 16,
  parameter int NB_ADDR    = 11,
  parameter int NB_DATA    = 16
);
  logic [NB_INSTRUC-1:0] i_instruc;
  logic [NB_DATA-1:0]    i_data_memory;
  logic                  i_mem_ready;
  logic [NB_ADDR-1:0]    o_addr_program_mem;
  logic [NB_ADDR-1:0]    o_addr_data_mem;
  logic [NB_DATA-1:0]    o_data_memory;
  logic                  o_WrRam;
  logic                  o_RdRam;
  logic                  o_halted;
  logic [NB_DATA-1:0]    o_acc;

  modport master (
    input  i_instruc, i_data_memory, i_mem_ready,
    output o_addr_program_mem, o_addr_data_mem, o_data_memory,
    output o_WrRam, o_RdRam, o_halted, o_acc
  );

  modport slave (
    output i_instruc, i_data_memory, i_mem_ready,
    input  o_addr_program_mem, o_addr_data_mem, o_data_memory,
    input  o_WrRam, o_RdRam, o_halted, o_acc
  );
endinterface

// File: rtl/bip_cpu_stall.sv
// Accumulator-based BIP core with a data-memory handshake: a memory
// instruction whose access is not ready is latched and the core waits in
// MEM_WAIT, holding PC, address, strobe and store data, until ready arrives.
module bip_cpu_stall #(
  parameter int NB_INSTRUC = 16,
  parameter int NB_OPCODE  = 5,
  parameter int NB_OPERAND = 11,
  parameter int NB_ADDR    = 11,
  parameter int NB_DATA    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  bip_cpu_stall_if.master  bus
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
  localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
  localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
  localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
  localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
  localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
  localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
  localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);
  localparam logic [NB_OPCODE-1:0] OP_AND  = NB_OPCODE'(8);
  localparam logic [NB_OPCODE-1:0] OP_ANDI = NB_OPCODE'(9);
  localparam logic [NB_OPCODE-1:0] OP_OR   = NB_OPCODE'(10);
  localparam logic [NB_OPCODE-1:0] OP_ORI  = NB_OPCODE'(11);
  localparam logic [NB_OPCODE-1:0] OP_XOR  = NB_OPCODE'(12);
  localparam logic [NB_OPCODE-1:0] OP_XORI = NB_OPCODE'(13);
  localparam logic [NB_OPCODE-1:0] OP_BEQZ = NB_OPCODE'(14);
  localparam logic [NB_OPCODE-1:0] OP_JMP  = NB_OPCODE'(15);

  state_t                state_q, state_d;
  logic [NB_ADDR-1:0]    pc_q, pc_d;
  logic [NB_DATA-1:0]    acc_q, acc_d;
  logic [NB_INSTRUC-1:0] instr_q, instr_d;

  logic [NB_INSTRUC-1:0] curInstr;
  logic [NB_OPCODE-1:0]  opcode;
  logic [NB_OPERAND-1:0] operand;
  logic [NB_DATA-1:0]    operandSext;
  logic [NB_DATA-1:0]    operandZext;
  logic                  isStore;
  logic                  isRead;
  logic                  busActive;

  // Decode: while waiting, the latched instruction replaces the program bus.
  always_comb begin
    curInstr    = (state_q == MEM_WAIT) ? instr_q : bus.i_instruc;
    opcode      = curInstr[NB_INSTRUC-1 -: NB_OPCODE];
    operand     = curInstr[NB_OPERAND-1:0];
    operandSext = NB_DATA'($signed(operand));
    operandZext = NB_DATA'(operand);
    isStore     = (opcode == OP_STO);
    isRead      = (opcode == OP_LD)  || (opcode == OP_ADD) || (opcode == OP_SUB) ||
                  (opcode == OP_AND) || (opcode == OP_OR)  || (opcode == OP_XOR);
    busActive   = !i_rst && (state_q != HALT);
  end

  // Bus outputs: strobes are combinational and suppressed during reset/halt.
  always_comb begin
    bus.o_addr_program_mem = pc_q;
    bus.o_addr_data_mem    = operand[NB_ADDR-1:0];
    bus.o_data_memory      = acc_q;
    bus.o_WrRam            = busActive && isStore;
    bus.o_RdRam            = busActive && isRead;
    bus.o_halted           = (state_q == HALT);
    bus.o_acc              = acc_q;
  end

  // Next-state and execute: an instruction completes unless its memory access stalls.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    instr_d = instr_q;
    case (state_q)
      HALT: begin
        state_d = HALT;
      end
      default: begin
        if (opcode == OP_HLT) begin
          state_d = HALT;
        end else if ((isStore || isRead) && !bus.i_mem_ready) begin
          state_d = MEM_WAIT;
          instr_d = curInstr;
        end else begin
          state_d = RUN;
          pc_d    = pc_q + NB_ADDR'(1);
          case (opcode)
            OP_LD:   acc_d = bus.i_data_memory;
            OP_LDI:  acc_d = operandSext;
            OP_ADD:  acc_d = acc_q + bus.i_data_memory;
            OP_ADDI: acc_d = acc_q + operandSext;
            OP_SUB:  acc_d = acc_q - bus.i_data_memory;
            OP_SUBI: acc_d = acc_q - operandSext;
            OP_AND:  acc_d = acc_q & bus.i_data_memory;
            OP_ANDI: acc_d = acc_q & operandZext;
            OP_OR:   acc_d = acc_q | bus.i_data_memory;
            OP_ORI:  acc_d = acc_q | operandZext;
            OP_XOR:  acc_d = acc_q ^ bus.i_data_memory;
            OP_XORI: acc_d = acc_q ^ operandZext;
            OP_BEQZ: begin
              if (acc_q == '0) pc_d = operand[NB_ADDR-1:0];
            end
            OP_JMP:  pc_d = operand[NB_ADDR-1:0];
            default: acc_d = acc_q;
          endcase
        end
      end
    endcase
  end

  // State registers with synchronous reset that also abandons a stalled access.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RUN;
      pc_q    <= '0;
      acc_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: tb/tb_bip_cpu_stall.sv
// Self-checking bench for bip_cpu_stall: directed scenarios with literal
// expectations followed by randomized programs checked against an ISA-level
// model of the core every cycle.
module tb_bip_cpu_stall;

  localparam int NB_INSTRUC = 16;
  localparam int NB_OPCODE  = 5;
  localparam int NB_OPERAND = 11;
  localparam int NB_ADDR    = 11;
  localparam int NB_DATA    = 16;

  logic clk = 1'b0;
  logic rst;

  bip_cpu_stall_if #(.NB_INSTRUC(NB_INSTRUC), .NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA)) bus ();

  bip_cpu_stall #(
    .NB_INSTRUC(NB_INSTRUC), .NB_OPCODE(NB_OPCODE), .NB_OPERAND(NB_OPERAND),
    .NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // ISA-level model state: program counter, accumulator, halted flag and a
  // pending memory instruction that has not yet seen ready.
  int          mPc;
  int          mAcc;
  bit          mHalted;
  bit          mWaiting;
  logic [15:0] mHeld;

  logic        sRst;
  logic [15:0] sInstr;
  logic [15:0] sData;
  logic        sReady;

  bit          expWr;
  bit          expRd;
  int          expAddr;
  int          expDout;
  bit          cmpEn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit isReadOp(input int op);
    return op inside {2, 4, 6, 8, 10, 12};
  endfunction

  // Drive one cycle of inputs and derive the bus outputs the model demands.
  task automatic applyStimulus(input logic [15:0] instr, input logic [15:0] data,
                               input logic ready, input logic r);
    logic [15:0] cur;
    int          op;
    bit          active;
    rst               = r;
    bus.i_instruc     = instr;
    bus.i_data_memory = data;
    bus.i_mem_ready   = ready;
    sRst   = r;
    sInstr = instr;
    sData  = data;
    sReady = ready;
    cur    = mWaiting ? mHeld : instr;
    op     = int'(cur[15:11]);
    active = !r && !mHalted;
    expWr   = active && (op == 1);
    expRd   = active && isReadOp(op);
    expAddr = int'(cur[10:0]);
    expDout = mAcc;
    #1;
  endtask

  // Execute the cycle's instruction in the model at the clock edge.
  task automatic modelUpdate();
    logic [15:0] cur;
    int op, opd, sx, d;
    if (sRst) begin
      mPc = 0; mAcc = 0; mHalted = 0; mWaiting = 0;
      return;
    end
    if (mHalted) return;
    cur = mWaiting ? mHeld : sInstr;
    op  = int'(cur[15:11]);
    opd = int'(cur[10:0]);
    sx  = (opd >= 1024) ? opd + 65536 - 2048 : opd;
    d   = int'(sData);
    if (op == 0) begin
      mHalted = 1;
      return;
    end
    if ((op == 1 || isReadOp(op)) && !sReady) begin
      mWaiting = 1;
      mHeld    = cur;
      return;
    end
    mWaiting = 0;
    mPc = (mPc + 1) % 2048;
    case (op)
      2:  mAcc = d;
      3:  mAcc = sx;
      4:  mAcc = (mAcc + d) % 65536;
      5:  mAcc = (mAcc + sx) % 65536;
      6:  mAcc = (mAcc - d + 65536) % 65536;
      7:  mAcc = (mAcc - sx + 65536) % 65536;
      8:  mAcc = mAcc & d;
      9:  mAcc = mAcc & opd;
      10: mAcc = mAcc | d;
      11: mAcc = mAcc | opd;
      12: mAcc = mAcc ^ d;
      13: mAcc = mAcc ^ opd;
      14: if (mAcc == 0) mPc = opd;
      15: mPc = opd;
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    modelUpdate();
  endtask

  // Single compare process: DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("pc", 32'(bus.o_addr_program_mem), 32'(mPc));
      checkOutput("acc", 32'(bus.o_acc), 32'(mAcc));
      checkOutput("halted", 32'(bus.o_halted), 32'(mHalted));
      checkOutput("WrRam", 32'(bus.o_WrRam), 32'(expWr));
      checkOutput("RdRam", 32'(bus.o_RdRam), 32'(expRd));
      if (expWr || expRd) checkOutput("addrData", 32'(bus.o_addr_data_mem), 32'(expAddr));
      if (expWr) checkOutput("dataOut", 32'(bus.o_data_memory), 32'(expDout));
    end
  end

  initial begin
    logic [15:0] rInstr;
    int          rOp;
    mPc = 0; mAcc = 0; mHalted = 0; mWaiting = 0; mHeld = '0;

    // Reset held two cycles with memory instructions on the bus.
    applyStimulus(16'h081D, 16'h0, 1'b1, 1'b1);
    checkOutput("rstWr", 32'(bus.o_WrRam), 32'd0);
    tick();
    cmpEn = 1'b1;
    applyStimulus(16'h1010, 16'h0, 1'b1, 1'b1);
    checkOutput("rstRd", 32'(bus.o_RdRam), 32'd0);
    tick();
    checkOutput("rstPc", 32'(bus.o_addr_program_mem), 32'd0);
    checkOutput("rstAcc", 32'(bus.o_acc), 32'd0);
    checkOutput("rstHalted", 32'(bus.o_halted), 32'd0);

    // LDI 5, ADDI -3, SUBI 3.
    applyStimulus(16'h1805, 16'h0, 1'b0, 1'b0); tick();
    checkOutput("ldiAcc", 32'(bus.o_acc), 32'h5);
    checkOutput("ldiPc", 32'(bus.o_addr_program_mem), 32'h1);
    applyStimulus(16'h2FFD, 16'h0, 1'b0, 1'b0); tick();
    checkOutput("addiAcc", 32'(bus.o_acc), 32'h2);
    checkOutput("addiPc", 32'(bus.o_addr_program_mem), 32'h2);
    applyStimulus(16'h3803, 16'h0, 1'b0, 1'b0); tick();
    checkOutput("subiAcc", 32'(bus.o_acc), 32'hFFFF);
    checkOutput("subiPc", 32'(bus.o_addr_program_mem), 32'h3);

    // Stalled store: ready low for 3 cycles, strobe held 4 cycles.
    applyStimulus(16'h18AB, 16'h0, 1'b1, 1'b0); tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus((i == 0) ? 16'h081D : 16'h1801, 16'($urandom), (i == 3), 1'b0);
      checkOutput("stoWr", 32'(bus.o_WrRam), 32'd1);
      checkOutput("stoAddr", 32'(bus.o_addr_data_mem), 32'h01D);
      checkOutput("stoData", 32'(bus.o_data_memory), 32'h00AB);
      checkOutput("stoPcHeld", 32'(bus.o_addr_program_mem), 32'h4);
      tick();
    end
    checkOutput("stoPcNext", 32'(bus.o_addr_program_mem), 32'h5);
    checkOutput("stoAcc", 32'(bus.o_acc), 32'h00AB);

    // Zero-wait load.
    applyStimulus(16'h1010, 16'h1234, 1'b1, 1'b0);
    checkOutput("ldRd", 32'(bus.o_RdRam), 32'd1);
    tick();
    checkOutput("ldAcc", 32'(bus.o_acc), 32'h1234);
    applyStimulus(16'hF800, 16'h0, 1'b1, 1'b0);
    checkOutput("ldRdOff", 32'(bus.o_RdRam), 32'd0);
    tick();

    // Branches and PC wrap.
    applyStimulus(16'h1800, 16'h0, 1'b0, 1'b0); tick();
    applyStimulus(16'h7040, 16'h0, 1'b0, 1'b0); tick();
    checkOutput("beqzTaken", 32'(bus.o_addr_program_mem), 32'h040);
    applyStimulus(16'h1801, 16'h0, 1'b0, 1'b0); tick();
    applyStimulus(16'h7040, 16'h0, 1'b0, 1'b0); tick();
    checkOutput("beqzNotTaken", 32'(bus.o_addr_program_mem), 32'h042);
    applyStimulus(16'h7FFF, 16'h0, 1'b0, 1'b0); tick();
    checkOutput("jmp", 32'(bus.o_addr_program_mem), 32'h7FF);
    applyStimulus(16'hF800, 16'h0, 1'b0, 1'b0); tick();
    checkOutput("pcWrap", 32'(bus.o_addr_program_mem), 32'h000);

    // Halt: PC frozen for 5 cycles, no strobes.
    applyStimulus(16'hF800, 16'h0, 1'b0, 1'b0); tick();
    applyStimulus(16'h0000, 16'h0, 1'b0, 1'b0); tick();
    checkOutput("halted", 32'(bus.o_halted), 32'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(16'h081D, 16'($urandom), 1'b1, 1'b0);
      checkOutput("haltWr", 32'(bus.o_WrRam), 32'd0);
      tick();
      checkOutput("haltPc", 32'(bus.o_addr_program_mem), 32'h1);
    end

    // Reset during MEM_WAIT abandons the access.
    applyStimulus(16'h0000, 16'h0, 1'b0, 1'b1); tick();
    applyStimulus(16'h1807, 16'h0, 1'b0, 1'b0); tick();
    applyStimulus(16'h0855, 16'h0, 1'b0, 1'b0); tick();
    applyStimulus(16'h1801, 16'h0, 1'b0, 1'b1);
    checkOutput("abortWr", 32'(bus.o_WrRam), 32'd0);
    tick();
    checkOutput("abortPc", 32'(bus.o_addr_program_mem), 32'h0);
    checkOutput("abortAcc", 32'(bus.o_acc), 32'h0);
    applyStimulus(16'hF800, 16'h0, 1'b1, 1'b0);
    checkOutput("abortNoWr", 32'(bus.o_WrRam), 32'd0);
    tick();

    // Randomized programs with random memory latency and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rOp = int'($urandom_range(0, 31));
      if (rOp == 0 && ($urandom % 8) != 0) rOp = 3;
      rInstr = {5'(rOp), 11'($urandom)};
      applyStimulus(rInstr, 16'($urandom), 1'($urandom % 2), ($urandom % 60) == 0);
      tick();
    end

    cmpEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
